// File: rtl/inst_mem_loader.sv
// inst_mem_loader: streams bytes into instruction memory as 16-bit little-endian words.
//
// Bytes arrive over a valid/ready handshake. Each pair forms one instruction word:
// the first byte is the low byte. The word is written to the next sequential word
// address with a single-cycle write pulse. While a load is in progress the
// processor is held (cpu_hold), so fetch never sees a half-written program.
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   start       one-cycle load request, honoured only when idle
//   base_addr   first word address of the load (latched on accepted start)
//   word_count  number of words to load (latched on accepted start)
//   in_data     stream byte
//   in_valid    in_data valid
//   in_ready    loader accepts a byte this cycle
//   mem_addr    instruction memory word address
//   mem_wdata   instruction word to write
//   mem_we      write enable, one-cycle pulse per word
//   mem_cs      chip select, asserted together with mem_we
//   busy        load in progress
//   done        level, set when a load finishes
//   error       level, set when the requested range runs past the end of memory
//   cpu_hold    holds fetch/PC until a load completes without error
module inst_mem_loader #(
  parameter int unsigned MEM_DEPTH = 1048576,
  parameter int unsigned COUNT_W   = 21
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [31:0]        base_addr,
  input  logic [COUNT_W-1:0] word_count,
  input  logic [7:0]         in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [31:0]        mem_addr,
  output logic [15:0]        mem_wdata,
  output logic               mem_we,
  output logic               mem_cs,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic               cpu_hold
);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StLow   = 3'd1,
    StHigh  = 3'd2,
    StWrite = 3'd3,
    StFin   = 3'd4
  } state_e;

  localparam logic [32:0] DepthW = 33'(MEM_DEPTH);

  state_e             state_q, state_d;
  logic [31:0]        ptr_q;
  logic [COUNT_W-1:0] remain_q;
  logic [7:0]         low_q;
  logic [31:0]        mem_addr_q;
  logic [15:0]        mem_wdata_q;
  logic               busy_q;
  logic               done_q;
  logic               error_q;
  logic               hold_q;

  // Range check at 33 bits so a base near 2^32 cannot wrap into a false pass.
  logic [32:0] end_addr;
  logic        range_bad;
  logic        load_empty;
  logic        last_word;

  assign end_addr   = {1'b0, base_addr} + 33'(word_count);
  assign range_bad  = end_addr > DepthW;
  assign load_empty = (word_count == '0);
  assign last_word  = (remain_q == COUNT_W'(1));

  // Next-state and decoded outputs.
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    mem_we   = 1'b0;
    mem_cs   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = (range_bad || load_empty) ? StFin : StLow;
        end
      end
      StLow: begin
        in_ready = 1'b1;
        if (in_valid) state_d = StHigh;
      end
      StHigh: begin
        in_ready = 1'b1;
        if (in_valid) state_d = StWrite;
      end
      StWrite: begin
        mem_we  = 1'b1;
        mem_cs  = 1'b1;
        state_d = last_word ? StFin : StLow;
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      remain_q    <= '0;
      low_q       <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      hold_q      <= 1'b1;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            ptr_q    <= base_addr;
            remain_q <= word_count;
            error_q  <= range_bad;
            hold_q   <= 1'b1;
            busy_q   <= !(range_bad || load_empty);
            // Degenerate loads go straight to FIN, so done is visible there.
            done_q   <= range_bad || load_empty;
          end
        end
        StLow: begin
          if (in_valid) low_q <= in_data;
        end
        StHigh: begin
          // Capture address and word here so they are stable for the whole
          // write cycle and then simply hold afterwards.
          if (in_valid) begin
            mem_addr_q  <= ptr_q;
            mem_wdata_q <= {in_data, low_q};
          end
        end
        StWrite: begin
          ptr_q    <= ptr_q + 32'd1;
          remain_q <= remain_q - COUNT_W'(1);
          if (last_word) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end
        StFin: begin
          // On error the processor stays held; the bad load released nothing.
          if (!error_q) hold_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;
  assign cpu_hold  = hold_q;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Self-checking bench for inst_mem_loader: a driver issues loads and pushes the
// expected memory writes into a queue; a monitor pops and compares on each write.
module tb_inst_mem_loader;

  localparam int unsigned DEPTH = 1048576;
  localparam int unsigned CW    = 21;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [31:0]   base_addr;
  logic [CW-1:0] word_count;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   mem_addr;
  logic [15:0]   mem_wdata;
  logic          mem_we;
  logic          mem_cs;
  logic          busy;
  logic          done;
  logic          error;
  logic          cpu_hold;

  inst_mem_loader #(
    .MEM_DEPTH (DEPTH),
    .COUNT_W   (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .word_count (word_count),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_cs     (mem_cs),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .cpu_hold   (cpu_hold)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] a;
    logic [15:0] d;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  fails  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every write must match the oldest outstanding expected write.
  initial begin
    wr_t w;
    forever begin
      @(negedge clk);
      if (rst !== 1'b1 && (mem_we === 1'b1 || mem_cs === 1'b1)) begin
        check("we_cs_together", mem_cs, mem_we);
        check("busy_during_write", busy, 1);
        if (exp_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_write: addr %0h data %0h with no write expected",
                   mem_addr, mem_wdata);
        end else begin
          w = exp_q.pop_front();
          check("write_addr", mem_addr, w.a);
          check("write_data", mem_wdata, w.d);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int stall);
    int n;
    if (stall > 0) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      repeat (stall) @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      fails++;
      $display("FAIL handshake_timeout: in_ready stayed 0, expected 1");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  // kind: 0 back-to-back, 1 random stalls, 2 five-cycle stall before the second byte.
  task automatic run_load(input logic [31:0] base, input int cnt, input int kind,
                          input bit mid, input logic [7:0] bytes[$]);
    bit               ovf;
    int               t0;
    int               n;
    longint unsigned  sum;
    int               s0;
    int               s1;
    sum = {32'd0, base} + longint'(cnt);
    ovf = sum > longint'(DEPTH);
    start      = 1'b1;
    base_addr  = base;
    word_count = CW'(cnt);
    @(posedge clk);
    #1;
    start      = 1'b0;
    base_addr  = $urandom;
    word_count = CW'($urandom);
    t0 = cyc;
    if (!ovf) begin
      for (int i = 0; i < cnt; i++) begin
        exp_q.push_back('{a: base + 32'(i), d: {bytes[2*i+1], bytes[2*i]}});
        if (mid && i == 1) begin
          start      = 1'b1;
          base_addr  = 32'h100;
          word_count = CW'(4);
          @(posedge clk);
          #1;
          start = 1'b0;
        end
        s0 = (kind == 1 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
        s1 = (kind == 1 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
        if (kind == 2 && i == 0) s1 = 5;
        send_byte(bytes[2*i], s0);
        send_byte(bytes[2*i+1], s1);
      end
    end
    n = 0;
    @(negedge clk);
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", done, 1);
    if (kind == 0 && !mid && !ovf && cnt > 0) check("latency_3n", cyc - t0, 3 * cnt);
    if (!ovf && cnt == 0) check("empty_done_quick", (cyc - t0) <= 1, 1);
    check("error_flag", error, ovf);
    check("busy_in_fin", busy, 0);
    check("hold_in_fin", cpu_hold, 1);
    check("writes_drained", exp_q.size(), 0);
    @(negedge clk);
    check("cpu_hold_after", cpu_hold, ovf ? 1 : 0);
    check("in_ready_idle", in_ready, 0);
    check("done_level", done, 1);
  endtask

  initial begin
    logic [7:0] q[$];
    logic [31:0] b;
    int          c;
    int          n;
    rst = 1'b1; start = 1'b0; base_addr = '0; word_count = '0;
    in_data = '0; in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_hold", cpu_hold, 1);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_we", mem_we, 0);
    @(posedge clk);
    #1;

    q = '{8'h34, 8'h12, 8'h78, 8'h56};
    run_load(32'h20, 2, 0, 1'b0, q);
    run_load(32'h20, 2, 2, 1'b0, q);
    run_load(32'(DEPTH - 1), 2, 0, 1'b0, q);
    run_load(32'h40, 0, 0, 1'b0, q);
    run_load(32'(DEPTH - 2), 2, 0, 1'b0, q);
    run_load(32'hFFFF_FFFF, 1, 0, 1'b0, q);

    q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    run_load(32'h20, 3, 0, 1'b1, q);

    // Reset after the first word of a three-word load.
    start = 1'b1; base_addr = 32'h40; word_count = CW'(3);
    @(posedge clk);
    #1;
    start = 1'b0;
    exp_q.push_back('{a: 32'h40, d: 16'hBBAA});
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    n = 0;
    @(negedge clk);
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("first_word_before_rst", exp_q.size(), 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_we", mem_we, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_hold", cpu_hold, 1);
    check("midrst_in_ready", in_ready, 0);
    check("midrst_mem_addr", mem_addr, 0);
    q = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    run_load(32'h300, 2, 0, 1'b0, q);

    for (int it = 0; it < 30; it++) begin
      c = int'($urandom_range(0, 5));
      case ($urandom_range(0, 3))
        0, 1: b = 32'($urandom_range(0, 4095));
        2:    b = 32'(DEPTH) - 32'($urandom_range(1, 8));
        default: b = $urandom;
      endcase
      q.delete();
      for (int k = 0; k < 2 * c; k++) q.push_back(8'($urandom));
      run_load(b, c, int'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0), q);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/inst_mem_loader.md
Name: inst_mem_loader

Overview:
- Writer-side counterpart to the fetch path's read-only use of instruction memory.
- Accepts a byte stream over a valid/ready handshake and assembles 16-bit instruction words.
- Writes the words sequentially into instruction memory through its write port (address, write data, write enable, chip select).
- Holds the processor in reset-hold while loading, so fetch never reads a partially loaded program.

Parameters:
- MEM_DEPTH, 1048576, instruction memory size in 16-bit words; the last valid address is MEM_DEPTH-1.
- COUNT_W, 21, width of the word_count input; must satisfy 2^COUNT_W > MEM_DEPTH.

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous active-high reset
start  input  1  one-cycle request to begin a load; sampled only in IDLE
base_addr  input  32  first word address to write; sampled on accepted start
word_count  input  COUNT_W  number of 16-bit words to load; sampled on accepted start
in_data  input  8  stream byte
in_valid  input  1  in_data valid
in_ready  output  1  loader accepts a byte this cycle when in_valid & in_ready
mem_addr  output  32  instruction memory word address
mem_wdata  output  16  instruction word to write
mem_we  output  1  memory write enable, one-cycle pulse per word
mem_cs  output  1  memory chip select; high in the same cycles as mem_we
busy  output  1  high from the cycle after an accepted start until the load finishes
done  output  1  level; high after a load finishes, cleared by the next accepted start or by rst
error  output  1  level; high when the requested range overflowed; cleared by the next accepted start or by rst
cpu_hold  output  1  holds fetch/PC; high while busy and from reset until the first successful done

Behaviour:
- Reset (rst=1 at posedge):
  - State goes to IDLE.
  - in_ready, mem_we, mem_cs, busy, done and error go to 0.
  - cpu_hold goes to 1.
  - mem_addr, mem_wdata and the internal word counter go to 0.
  - Any partial word is discarded. Reset wins over every other input in the same cycle, including mid-load.
- States: IDLE, LOW, HIGH, WRITE, FIN.
- IDLE:
  - in_ready=0.
  - start=1: latch base_addr into the address pointer and word_count into the remaining counter, and clear done and error.
  - Range check in the same cycle: if base_addr + word_count > MEM_DEPTH (computed at 33 bits, no wrap), set error=1 and go to FIN with no writes.
  - Otherwise, if word_count==0, go to FIN with no writes.
  - Otherwise set busy=1 and go to LOW.
- LOW:
  - in_ready=1.
  - On a handshake, the byte goes to word bits [7:0]; go to HIGH.
- HIGH:
  - in_ready=1.
  - On a handshake, the byte goes to bits [15:8]; go to WRITE.
  - Byte order is little-endian: the first byte received is the low byte.
- WRITE (exactly one cycle):
  - in_ready=0; mem_we=1 and mem_cs=1.
  - mem_addr = current pointer; mem_wdata = assembled word.
  - On exit, increment the pointer by 1 and decrement the remaining counter.
  - If the remaining count becomes 0, go to FIN; else go to LOW.
- FIN (one cycle):
  - busy=0 and done=1.
  - cpu_hold=0 only if error=0; on error, cpu_hold keeps its previous value.
  - Go to IDLE.
- Latency:
  - The write pulse occurs the cycle after the high-byte handshake.
  - Minimum time for N words is 3N cycles after leaving IDLE, plus 1 cycle for FIN.
- Stalls: in_valid=0 in LOW or HIGH holds the state indefinitely with no timeout. in_data is ignored when in_valid=0.
- start while not in IDLE is ignored; the latched parameters are unaffected.
- cpu_hold rises to 1 in the cycle after any accepted start and stays high through FIN's error case.
- The loader never wraps mem_addr; the range check guarantees addresses stay ≤ MEM_DEPTH-1.
- Outside WRITE, mem_we=0 and mem_cs=0, and mem_addr/mem_wdata hold their last values.

Test Plan:
- rst, then start with base_addr=0x20 and word_count=2; stream bytes 0x34, 0x12, 0x78, 0x56 back-to-back. Required: two mem_we pulses, (0x20, 0x1234) then (0x21, 0x5678); then done=1, cpu_hold=0, busy=0.
- Same load with in_valid low for 5 cycles between bytes 1 and 2. Required: state holds, no extra writes, identical memory contents.
- start with base_addr=MEM_DEPTH-1 and word_count=2. Required: error=1, done=1, zero mem_we pulses, cpu_hold remains 1.
- start with word_count=0. Required: done=1 within 2 cycles, no writes, cpu_hold=0.
- Assert rst after the first word is written of a 3-word load. Required: next cycle is IDLE with mem_we=0, busy=0, done=0 and cpu_hold=1; a restarted load writes correctly from the new base_addr.
- Pulse start again mid-load (base_addr=0x100). Required: ignored; writes continue at the original addresses.
